// File: rtl/cam_cmd_issuer.sv
// CAM command issuer: packs a load list into storage beats, streams
// queries as SEARCH_MQ beats and counts hits from the CAM result stream.
module cam_cmd_issuer #(
  parameter int          C_DATA_WIDTH = 520,
  parameter int          CAM_SIZE     = 128,
  parameter int          CNT_WIDTH    = 32,
  parameter logic [31:0] PAD_KEY      = 32'hFFFF_FFFF
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic                    ld_tvalid,
  output logic                    ld_tready,
  input  logic                    ld_tlast,
  input  logic [31:0]             ld_tdata,
  input  logic                    q_tvalid,
  output logic                    q_tready,
  input  logic                    q_tlast,
  input  logic [31:0]             q_tdata,
  output logic                    m_tvalid,
  output logic [C_DATA_WIDTH-1:0] m_tdata,
  input  logic                    r_tvalid,
  input  logic [C_DATA_WIDTH-1:0] r_tdata,
  output logic                    cnt_tvalid,
  input  logic                    cnt_tready,
  output logic [CNT_WIDTH-1:0]    cnt_tdata,
  output logic                    busy,
  output logic                    ovf
);

  localparam int NBEAT = CAM_SIZE / 16;
  localparam int BW    = $clog2(NBEAT + 1);

  localparam logic [3:0] OP_SEARCH = 4'd5;
  localparam logic [3:0] OP_RESET  = 4'd7;
  localparam logic [3:0] OP_UPDATE = 4'd8;
  localparam logic [3:0] OP_EOS    = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_LOAD,
    S_QUERY,
    S_EOS,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             lanes_q [16];
  logic [31:0]             lanes_d [16];
  logic [3:0]              lcnt_q, lcnt_d;
  logic [BW-1:0]           bcnt_q, bcnt_d;
  logic [CNT_WIDTH-1:0]    cnt_d, cnt_inc;
  logic                    ovf_d, busy_d, cvld_d;
  logic                    ld_rdy_d, q_rdy_d;
  logic                    mvld_d;
  logic [3:0]              op_d;
  logic [511:0]            mdata_d, fill;
  logic [C_DATA_WIDTH-1:0] m_tdata_d;
  logic                    ld_acc, q_acc, hit, r_eos;
  logic [3:0]              r_op;
  logic                    unused_r;

  assign unused_r = ^{r_tdata[C_DATA_WIDTH-1], r_tdata[514:1]};

  assign ld_acc  = ld_tvalid & ld_tready;
  assign q_acc   = q_tvalid & q_tready;
  assign r_op    = r_tdata[518:515];
  assign hit     = r_tvalid && (r_op == OP_SEARCH) && r_tdata[0];
  assign r_eos   = r_tvalid && (r_op == OP_EOS);
  assign cnt_inc = (&cnt_tdata) ? cnt_tdata : cnt_tdata + CNT_WIDTH'(1);

  // Storage beat: buffered lanes, then the current key, then padding.
  always_comb begin
    fill = '0;
    for (int k = 0; k < 16; k++) begin
      if (k < int'(lcnt_q))
        fill[32*k +: 32] = lanes_q[k];
      else if (k == int'(lcnt_q))
        fill[32*k +: 32] = ld_tdata;
      else
        fill[32*k +: 32] = PAD_KEY;
    end
  end

  always_comb begin
    state_d = state_q;
    lanes_d = lanes_q;
    lcnt_d  = lcnt_q;
    bcnt_d  = bcnt_q;
    cnt_d   = cnt_tdata;
    ovf_d   = ovf;
    busy_d  = busy;
    cvld_d  = 1'b0;
    mvld_d  = 1'b0;
    op_d    = 4'd0;
    mdata_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (ld_tvalid) begin
          state_d = S_RST;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          lcnt_d  = '0;
          bcnt_d  = '0;
          busy_d  = 1'b1;
          mvld_d  = 1'b1;
          op_d    = OP_RESET;
        end
      end
      S_RST, S_LOAD: begin
        state_d = S_LOAD;
        if (ld_acc) begin
          if (bcnt_q == BW'(NBEAT)) begin
            ovf_d = 1'b1;
          end else begin
            lanes_d[lcnt_q] = ld_tdata;
            if (lcnt_q == 4'd15 || ld_tlast) begin
              mvld_d  = 1'b1;
              op_d    = OP_UPDATE;
              mdata_d = fill;
              lcnt_d  = '0;
              bcnt_d  = bcnt_q + BW'(1);
            end else begin
              lcnt_d = lcnt_q + 4'd1;
            end
          end
          if (ld_tlast) state_d = S_QUERY;
        end
      end
      S_QUERY: begin
        if (hit) cnt_d = cnt_inc;
        if (q_acc) begin
          // 0 and PAD_KEY would match reset/padding entries.
          if (q_tdata != '0 && q_tdata != PAD_KEY) begin
            mvld_d  = 1'b1;
            op_d    = OP_SEARCH;
            mdata_d = {480'd0, q_tdata};
          end
          if (q_tlast) state_d = S_EOS;
        end
      end
      S_EOS: begin
        if (hit) cnt_d = cnt_inc;
        mvld_d  = 1'b1;
        op_d    = OP_EOS;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (hit) cnt_d = cnt_inc;
        if (r_eos) begin
          state_d = S_DONE;
          cvld_d  = 1'b1;
        end
      end
      S_DONE: begin
        cvld_d = 1'b1;
        if (cnt_tready) begin
          state_d = S_IDLE;
          cvld_d  = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ld_rdy_d  = (state_d == S_RST) || (state_d == S_LOAD);
    q_rdy_d   = (state_d == S_QUERY);
    m_tdata_d = '0;
    m_tdata_d[518:515] = op_d;
    m_tdata_d[511:0]   = mdata_d;
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q    <= S_IDLE;
      lanes_q    <= '{default: '0};
      lcnt_q     <= '0;
      bcnt_q     <= '0;
      cnt_tdata  <= '0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
      cnt_tvalid <= 1'b0;
      ld_tready  <= 1'b0;
      q_tready   <= 1'b0;
      m_tvalid   <= 1'b0;
      m_tdata    <= '0;
    end else begin
      state_q    <= state_d;
      lanes_q    <= lanes_d;
      lcnt_q     <= lcnt_d;
      bcnt_q     <= bcnt_d;
      cnt_tdata  <= cnt_d;
      ovf        <= ovf_d;
      busy       <= busy_d;
      cnt_tvalid <= cvld_d;
      ld_tready  <= ld_rdy_d;
      q_tready   <= q_rdy_d;
      m_tvalid   <= mvld_d;
      m_tdata    <= m_tdata_d;
    end
  end

endmodule

// File: tb/tb_cam_cmd_issuer.sv
// Bench for cam_cmd_issuer: list-level reference model of the beat
// stream and hit count, plus a behavioural CAM with fixed latency.
module tb_cam_cmd_issuer;

  localparam int DW     = 520;
  localparam int CW     = 32;
  localparam int CSZ    = 128;
  localparam int LAT    = 3;
  localparam int BUDGET = 2000;
  localparam logic [31:0] PAD = 32'hFFFF_FFFF;
  localparam logic [3:0] OP_S = 4'd5;
  localparam logic [3:0] OP_R = 4'd7;
  localparam logic [3:0] OP_U = 4'd8;
  localparam logic [3:0] OP_E = 4'hF;

  logic          aclk = 1'b0;
  logic          areset_n = 1'b0;
  logic          ld_tvalid = 1'b0, ld_tlast = 1'b0, ld_tready;
  logic [31:0]   ld_tdata = '0;
  logic          q_tvalid = 1'b0, q_tlast = 1'b0, q_tready;
  logic [31:0]   q_tdata = '0;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          r_tvalid = 1'b0;
  logic [DW-1:0] r_tdata = '0;
  logic          cnt_tvalid, cnt_tready = 1'b0;
  logic [CW-1:0] cnt_tdata;
  logic          busy, ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 aclk = ~aclk;

  cam_cmd_issuer #(
    .C_DATA_WIDTH(DW), .CAM_SIZE(CSZ), .CNT_WIDTH(CW), .PAD_KEY(PAD)
  ) dut (
    .aclk(aclk), .areset_n(areset_n),
    .ld_tvalid(ld_tvalid), .ld_tready(ld_tready),
    .ld_tlast(ld_tlast), .ld_tdata(ld_tdata),
    .q_tvalid(q_tvalid), .q_tready(q_tready),
    .q_tlast(q_tlast), .q_tdata(q_tdata),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata),
    .r_tvalid(r_tvalid), .r_tdata(r_tdata),
    .cnt_tvalid(cnt_tvalid), .cnt_tready(cnt_tready),
    .cnt_tdata(cnt_tdata), .busy(busy), .ovf(ovf)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } res_t;

  logic [DW-1:0] exp_q [$];
  res_t          pend [$];
  bit            cam [logic [31:0]];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  always @(posedge aclk) cyc = cyc + 1;

  // Beat checker and CAM model.
  always @(negedge aclk) begin : mon
    logic [DW-1:0] e;
    res_t          r;
    logic [3:0]    op;
    if (areset_n) begin
      checks++;
      if (m_tvalid) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_extra got %h", m_tdata);
        end else begin
          e = exp_q.pop_front();
          if (m_tdata !== e) begin
            errors++;
            $display("FAIL beat got %h want %h", m_tdata, e);
          end
        end
        op = m_tdata[518:515];
        r.d = '0;
        r.d[518:515] = op;
        if (op == OP_R) cam.delete();
        if (op == OP_U)
          for (int k = 0; k < 16; k++) cam[m_tdata[32*k +: 32]] = 1'b1;
        if (op == OP_S) r.d[0] = cam.exists(m_tdata[31:0]);
        r.due = cyc + LAT;
        pend.push_back(r);
      end else if (m_tdata !== '0) begin
        errors++;
        $display("FAIL idle_data got %h want 0", m_tdata);
      end
    end
  end

  always @(posedge aclk) begin : drv_r
    res_t r;
    #1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      r_tvalid = 1'b1;
      r_tdata  = r.d;
    end else begin
      r_tvalid = 1'b0;
      r_tdata  = '0;
    end
  end

  // List-level model: expected beats, count and overflow.
  task automatic build_exp(input logic [31:0] L[$], input logic [31:0] Q[$],
                           output int cnt, output int nupd,
                           output int nsrch, output bit eovf);
    logic [DW-1:0] b;
    int n;
    n = (L.size() > CSZ) ? CSZ : L.size();
    cnt = 0; nupd = 0; nsrch = 0;
    eovf = (L.size() > CSZ);
    b = '0; b[518:515] = OP_R; exp_q.push_back(b);
    for (int i = 0; i < n; i += 16) begin
      b = '0; b[518:515] = OP_U;
      for (int k = 0; k < 16; k++)
        b[32*k +: 32] = (i + k < n) ? L[i+k] : PAD;
      exp_q.push_back(b);
      nupd++;
    end
    foreach (Q[j]) begin
      if (Q[j] != 32'd0 && Q[j] != PAD) begin
        b = '0; b[518:515] = OP_S; b[31:0] = Q[j];
        exp_q.push_back(b);
        nsrch++;
        for (int i = 0; i < n; i++)
          if (L[i] == Q[j]) begin cnt++; break; end
      end
    end
    b = '0; b[518:515] = OP_E; exp_q.push_back(b);
  endtask

  task automatic wait_rdy(input int which, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge aclk);
      if ((which == 0) ? ld_tready : q_tready) begin
        @(posedge aclk);
        ok = 1'b1;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL timeout_%s got none want handshake",
             (which == 0) ? "ld" : "q");
  endtask

  task automatic drive_load(input logic [31:0] L[$], input int gap);
    bit ok;
    foreach (L[i]) begin
      if (gap > 0 && $urandom_range(0, 3) == 0) begin
        ld_tvalid = 1'b0;
        repeat ($urandom_range(1, gap)) @(posedge aclk);
        #1;
      end
      ld_tvalid = 1'b1;
      ld_tdata  = L[i];
      ld_tlast  = (i == L.size() - 1);
      wait_rdy(0, ok);
      #1;
      if (!ok) break;
    end
    ld_tvalid = 1'b0;
    ld_tlast  = 1'b0;
  endtask

  task automatic drive_q(input logic [31:0] Q[$], input int gap);
    bit ok;
    foreach (Q[i]) begin
      if (gap > 0 && $urandom_range(0, 3) == 0) begin
        q_tvalid = 1'b0;
        repeat ($urandom_range(1, gap)) @(posedge aclk);
        #1;
      end
      q_tvalid = 1'b1;
      q_tdata  = Q[i];
      q_tlast  = (i == Q.size() - 1);
      wait_rdy(1, ok);
      #1;
      if (!ok) break;
    end
    q_tvalid = 1'b0;
    q_tlast  = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] L[$], input logic [31:0] Q[$],
                         input int gap, input int hold,
                         output int cnt, output int nupd, output int nsrch);
    bit eovf, seen;
    build_exp(L, Q, cnt, nupd, nsrch, eovf);
    fork
      drive_load(L, gap);
      drive_q(Q, gap);
    join
    seen = 1'b0;
    for (int n = 0; n < BUDGET && !seen; n++) begin
      @(negedge aclk);
      seen = cnt_tvalid;
    end
    chk("cnt_tvalid_rise", seen, 1'b1);
    if (!seen) return;
    for (int h = 0; h < hold; h++) begin
      chk("hold_tvalid", cnt_tvalid, 1'b1);
      chk("hold_tdata", cnt_tdata, cnt);
      chk("hold_ld_tready", ld_tready, 1'b0);
      @(negedge aclk);
    end
    chk("busy_done", busy, 1'b1);
    chk("ovf", ovf, eovf);
    chk("cnt_tdata", cnt_tdata, cnt);
    cnt_tready = 1'b1;
    @(posedge aclk);
    #1 cnt_tready = 1'b0;
    @(negedge aclk);
    chk("busy_fall", busy, 1'b0);
    chk("cnt_tvalid_fall", cnt_tvalid, 1'b0);
    chk("beats_left", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] L[$];
    logic [31:0] Q[$];
    int c, u, s, r;
    bit ok;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_m_tdata", (m_tdata == '0), 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_cnt_tvalid", cnt_tvalid, 1'b0);
    chk("rst_ld_tready", ld_tready, 1'b0);
    chk("rst_q_tready", q_tready, 1'b0);
    areset_n = 1'b1;
    @(posedge aclk); #1;

    L = '{32'd5, 32'd9, 32'd12};
    Q = '{32'd9, 32'd7, 32'd12, 32'd5};
    run_job(L, Q, 0, 0, c, u, s);
    chk("pin_cnt_basic", c, 3);
    chk("pin_upd_basic", u, 1);
    chk("pin_srch_basic", s, 4);

    L.delete();
    for (int i = 1; i <= 16; i++) L.push_back(32'(i));
    Q = '{32'd16, 32'd3, 32'd99};
    run_job(L, Q, 1, 0, c, u, s);
    chk("pin_upd_16", u, 1);
    chk("pin_cnt_16", c, 2);

    L.push_back(32'd17);
    Q = '{32'd17};
    run_job(L, Q, 0, 0, c, u, s);
    chk("pin_upd_17", u, 2);

    L.delete();
    for (int i = 1; i <= 130; i++) L.push_back(32'(i));
    Q = '{32'd129, 32'd130, 32'd128};
    run_job(L, Q, 0, 0, c, u, s);
    chk("pin_upd_130", u, 8);
    chk("pin_cnt_130", c, 1);

    L = '{32'd9};
    Q = '{32'd0, PAD, 32'd9};
    run_job(L, Q, 0, 0, c, u, s);
    chk("pin_srch_rsv", s, 1);
    chk("pin_cnt_rsv", c, 1);

    L = '{32'd3, 32'd4};
    Q = '{32'd4};
    run_job(L, Q, 0, 10, c, u, s);
    chk("pin_cnt_hold", c, 1);

    // Abort a job mid-query with an asynchronous reset.
    L = '{32'd1, 32'd2, 32'd3};
    Q.delete();
    for (int i = 0; i < 20; i++) Q.push_back(32'd2);
    build_exp(L, Q, c, u, s, ok);
    drive_load(L, 0);
    q_tvalid = 1'b1; q_tdata = 32'd2; q_tlast = 1'b0;
    wait_rdy(1, ok);
    repeat (3) @(negedge aclk);
    chk("pre_rst_m_tvalid", m_tvalid, 1'b1);
    #2 areset_n = 1'b0;
    #1;
    chk("arst_m_tvalid", m_tvalid, 1'b0);
    chk("arst_m_tdata", (m_tdata == '0), 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_q_tready", q_tready, 1'b0);
    q_tvalid = 1'b0;
    exp_q.delete();
    pend.delete();
    @(negedge aclk);
    areset_n = 1'b1;
    @(posedge aclk); #1;
    L = '{32'd7, 32'd8};
    Q = '{32'd8, 32'd2, 32'd7};
    run_job(L, Q, 0, 0, c, u, s);
    chk("pin_cnt_after_rst", c, 2);

    for (int j = 0; j < 8; j++) begin
      int nl, nq;
      L.delete();
      Q.delete();
      nl = ($urandom_range(0, 4) == 0) ? $urandom_range(120, 150)
                                       : $urandom_range(1, 40);
      for (int i = 0; i < nl; i++) L.push_back(32'($urandom_range(1, 200)));
      nq = $urandom_range(1, 20);
      for (int i = 0; i < nq; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      Q.push_back(32'd0);
        else if (r == 1) Q.push_back(PAD);
        else             Q.push_back(32'($urandom_range(1, 200)));
      end
      run_job(L, Q, $urandom_range(0, 3), $urandom_range(0, 4), c, u, s);
    end

    repeat (5) @(posedge aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
